// File: rtl/feature_packetizer.sv
// Serializes one feature set into a 27-byte UART telemetry packet:
// sync pair, big-endian fields, XOR checksum of the payload bytes.
module feature_packetizer #(
    parameter int NUM_BANDS = 8,
    parameter logic [7:0] SYNC0 = 8'hAA,
    parameter logic [7:0] SYNC1 = 8'h55
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      feat_strobe,
    input  logic [15:0]               frame_cnt,
    input  logic [15:0]               peak_bin,
    input  logic [15:0]               peak_mag,
    input  logic [16*NUM_BANDS-1:0]   bands,
    input  logic [15:0]               centroid,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic                      busy,
    output logic [7:0]                drop_cnt
);
    localparam int SW = 16 * (NUM_BANDS + 4);
    localparam logic [4:0] LAST = 5'(2 + 2 * (NUM_BANDS + 4));

    typedef enum logic {IDLE, SEND} state_t;

    // Handshake: a byte moves on any cycle where tx_valid and tx_ready are both
    // high; tx_data is held stable while tx_valid is high and tx_ready is low.
    state_t          state;
    state_t          state_nxt;
    logic [SW-1:0]   shadow;
    logic [SW-1:0]   shadow_in;
    logic [SW-1:0]   shifted;
    logic [16*NUM_BANDS-1:0] bands_be;
    logic [4:0]      index;
    logic [4:0]      pidx;
    logic [7:0]      chk;
    logic [7:0]      cur_byte;
    logic            xfer;

    // Band 0 goes first on the wire, so reverse band order into the shadow word.
    always_comb begin
        bands_be = '0;
        for (int k = 0; k < NUM_BANDS; k++) begin
            bands_be[16*(NUM_BANDS-1-k) +: 16] = bands[16*k +: 16];
        end
    end

    assign shadow_in = {frame_cnt, peak_bin, peak_mag, bands_be, centroid};
    assign xfer      = tx_valid & tx_ready;
    assign pidx      = index - 5'd2;
    assign shifted   = shadow << {pidx, 3'b000};

    always_comb begin
        cur_byte = shifted[SW-1 -: 8];
        if (index == 5'd0) begin
            cur_byte = SYNC0;
        end else if (index == 5'd1) begin
            cur_byte = SYNC1;
        end else if (index == LAST) begin
            cur_byte = chk;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (feat_strobe) state_nxt = SEND;
            SEND: if (xfer && index == LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        tx_valid = 1'b0;
        busy     = 1'b0;
        tx_data  = 8'h00;
        if (state == SEND) begin
            tx_valid = 1'b1;
            busy     = 1'b1;
            tx_data  = cur_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow   <= '0;
            index    <= '0;
            chk      <= '0;
            drop_cnt <= '0;
        end else begin
            if (state == IDLE && feat_strobe) begin
                shadow <= shadow_in;
                chk    <= '0;
                index  <= '0;
            end else if (state == SEND && xfer) begin
                index <= (index == LAST) ? 5'd0 : index + 5'd1;
                if (index >= 5'd2 && index < LAST) begin
                    chk <= chk ^ cur_byte;
                end
            end
            // Strobe during the last-byte transfer still counts: busy is high then.
            if (state == SEND && feat_strobe && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_feature_packetizer.sv
// Directed bench for feature_packetizer: expected bytes go into a queue,
// a negedge monitor pops and compares each transferred byte.
module tb_feature_packetizer;
    logic         clk = 1'b0;
    logic         rst;
    logic         feat_strobe;
    logic [15:0]  frame_cnt;
    logic [15:0]  peak_bin;
    logic [15:0]  peak_mag;
    logic [127:0] bands;
    logic [15:0]  centroid;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         busy;
    logic [7:0]   drop_cnt;

    logic [7:0] exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    feature_packetizer dut (
        .clk(clk), .rst(rst), .feat_strobe(feat_strobe),
        .frame_cnt(frame_cnt), .peak_bin(peak_bin), .peak_mag(peak_mag),
        .bands(bands), .centroid(centroid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .drop_cnt(drop_cnt)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted byte must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_byte: got %0h expected none", tx_data);
            end else begin
                check("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [15:0] fc, input logic [15:0] pb, input logic [15:0] pm,
                              input logic [127:0] b, input logic [15:0] c);
        frame_cnt = fc; peak_bin = pb; peak_mag = pm; bands = b; centroid = c;
    endtask

    // Reference model of the packet, built field by field.
    task automatic push_packet(input logic [15:0] fc, input logic [15:0] pb, input logic [15:0] pm,
                               input logic [127:0] b, input logic [15:0] c);
        logic [7:0] pay[$];
        logic [7:0] x;
        pay.push_back(fc[15:8]); pay.push_back(fc[7:0]);
        pay.push_back(pb[15:8]); pay.push_back(pb[7:0]);
        pay.push_back(pm[15:8]); pay.push_back(pm[7:0]);
        for (int k = 0; k < 8; k++) begin
            pay.push_back(b[16*k+8 +: 8]);
            pay.push_back(b[16*k +: 8]);
        end
        pay.push_back(c[15:8]); pay.push_back(c[7:0]);
        x = 8'h00;
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h55);
        foreach (pay[i]) begin
            x ^= pay[i];
            exp_q.push_back(pay[i]);
        end
        exp_q.push_back(x);
    endtask

    // Driver: one-cycle strobe, then scramble inputs to prove they were shadowed.
    task automatic strobe(input logic [15:0] fc, input logic [15:0] pb, input logic [15:0] pm,
                          input logic [127:0] b, input logic [15:0] c);
        set_fields(fc, pb, pm, b, c);
        feat_strobe = 1'b1;
        tick();
        feat_strobe = 1'b0;
        set_fields(16'hDEAD, 16'hBEEF, 16'hCAFE, {8{16'hF00D}}, 16'h5A5A);
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy && cycles < 200) begin
            cycles++;
            tick();
        end
        if (busy) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_idle_timeout: got busy=1 expected busy=0");
        end
    endtask

    logic [127:0] band_ramp;
    logic [7:0]   basic_hdr[8];
    int cyc;

    initial begin
        rst = 1'b1; feat_strobe = 1'b0; tx_ready = 1'b1;
        set_fields(16'h0, 16'h0, 16'h0, 128'h0, 16'h0);
        repeat (3) tick();
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_tx_data", {24'h0, tx_data}, 32'h0);
        check("rst_drop_cnt", {24'h0, drop_cnt}, 32'h0);
        rst = 1'b0;
        tick();

        // Basic packet, hand-written expected bytes.
        basic_hdr = '{8'hAA, 8'h55, 8'h00, 8'h01, 8'h00, 8'h0B, 8'h12, 8'h34};
        foreach (basic_hdr[i]) exp_q.push_back(basic_hdr[i]);
        for (int i = 0; i < 16; i++) exp_q.push_back(8'h00);
        exp_q.push_back(8'h00); exp_q.push_back(8'h0B); exp_q.push_back(8'h27);
        strobe(16'h0001, 16'h000B, 16'h1234, 128'h0, 16'h000B);
        check("latency_valid", {31'h0, tx_valid}, 32'h1);
        check("latency_sync0", {24'h0, tx_data}, 32'hAA);
        wait_idle(cyc);
        check("busy_cycles", cyc, 27);
        check("idle_tx_valid", {31'h0, tx_valid}, 32'h0);

        // Band ordering.
        for (int k = 0; k < 8; k++) band_ramp[16*k +: 16] = 16'h0100 + 16'(k);
        push_packet(16'h0002, 16'h0003, 16'h4567, band_ramp, 16'h0020);
        strobe(16'h0002, 16'h0003, 16'h4567, band_ramp, 16'h0020);
        wait_idle(cyc);

        // Backpressure at index 3: byte 0x01 held for the whole stall.
        push_packet(16'h0001, 16'h000B, 16'h1234, 128'h0, 16'h000B);
        strobe(16'h0001, 16'h000B, 16'h1234, 128'h0, 16'h000B);
        repeat (3) tick();
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", {31'h0, tx_valid}, 32'h1);
            check("stall_data", {24'h0, tx_data}, 32'h01);
        end
        tx_ready = 1'b1;
        wait_idle(cyc);

        // Overrun mid-packet, on the last-byte transfer, and one cycle later.
        push_packet(16'h0010, 16'h0123, 16'h8001, band_ramp, 16'h0042);
        strobe(16'h0010, 16'h0123, 16'h8001, band_ramp, 16'h0042);
        repeat (10) tick();
        feat_strobe = 1'b1;
        tick();
        feat_strobe = 1'b0;
        check("drop_mid", {24'h0, drop_cnt}, 32'h1);
        repeat (15) tick();
        feat_strobe = 1'b1;
        tick();
        feat_strobe = 1'b0;
        check("drop_last_byte", {24'h0, drop_cnt}, 32'h2);
        check("idle_after_last", {31'h0, busy}, 32'h0);
        push_packet(16'h0011, 16'h00FF, 16'h7FFE, {8{16'hA5C3}}, 16'h0101);
        strobe(16'h0011, 16'h00FF, 16'h7FFE, {8{16'hA5C3}}, 16'h0101);
        check("restart_valid", {31'h0, tx_valid}, 32'h1);
        check("restart_sync0", {24'h0, tx_data}, 32'hAA);
        wait_idle(cyc);

        // Saturation: 300 strobes while the sink is stalled.
        push_packet(16'h0020, 16'h0004, 16'h0005, 128'h0, 16'h0006);
        strobe(16'h0020, 16'h0004, 16'h0005, 128'h0, 16'h0006);
        tx_ready = 1'b0;
        feat_strobe = 1'b1;
        repeat (300) tick();
        feat_strobe = 1'b0;
        check("drop_saturate", {24'h0, drop_cnt}, 32'hFF);
        check("sat_held_sync0", {24'h0, tx_data}, 32'hAA);
        tx_ready = 1'b1;
        wait_idle(cyc);

        // Reset mid-packet at index 12.
        push_packet(16'h0030, 16'h0007, 16'h0008, band_ramp, 16'h0009);
        strobe(16'h0030, 16'h0007, 16'h0008, band_ramp, 16'h0009);
        repeat (12) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("midrst_busy", {31'h0, busy}, 32'h0);
        check("midrst_drop_cnt", {24'h0, drop_cnt}, 32'h0);
        exp_q.delete();
        push_packet(16'h0031, 16'h1111, 16'h2222, {8{16'h3344}}, 16'h5566);
        strobe(16'h0031, 16'h1111, 16'h2222, {8{16'h3344}}, 16'h5566);
        wait_idle(cyc);
        tick();
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
